// File: rtl/ysyx_25040105_core_seq.sv
// ysyx_25040105_core_seq
// Multi-cycle sequencer for the ysyx_25040105 core. It walks each instruction
// through fetch (valid/ready imem port), decode/execute, an optional data
// access and write-back. It gates the PC update and register-file write so
// each instruction retires exactly once. It also owns ebreak halt with
// good/bad trap reporting, a memory-wait watchdog and a retired counter.
//
// Ports
//   clk, rst                     clock, synchronous active-low reset
//   imem_req_valid_o/ready_i     fetch request handshake (address = IFU pc)
//   imem_rsp_valid_i/inst_i      fetch response
//   inst_o                       instruction register, feeds the IDU
//   dec_is_mem_i, dec_is_ebreak_i, a0_zero_i   decode/regfile status
//   dmem_req_valid_o/ready_i     data request handshake
//   dmem_rsp_valid_i             data response / store ack
//   pc_we_o, reg_we_o            one-cycle retire strobes (WB only)
//   halted_o, exit_good_o        ebreak retired (sticky), a0 == 0 at ebreak
//   timeout_err_o                watchdog fired (sticky)
//   retired_o                    retired instruction count (wraps)
module ysyx_25040105_core_seq #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_inst_i,
  output logic [31:0] inst_o,
  input  logic        dec_is_mem_i,
  input  logic        dec_is_ebreak_i,
  input  logic        a0_zero_i,
  output logic        dmem_req_valid_o,
  input  logic        dmem_req_ready_i,
  input  logic        dmem_rsp_valid_i,
  output logic        pc_we_o,
  output logic        reg_we_o,
  output logic        halted_o,
  output logic        exit_good_o,
  output logic        timeout_err_o,
  output logic [31:0] retired_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT_I, S_EXEC, S_MREQ, S_WAIT_D, S_WB, S_HALT, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wd_q, wd_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ret_q, ret_d;
  logic        exit_q, exit_d;
  logic        waiting;

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    ret_d   = ret_q;
    exit_d  = exit_q;
    waiting = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        waiting = 1'b1;
        if (imem_req_ready_i) state_d = S_WAIT_I;
      end
      S_WAIT_I: begin
        waiting = 1'b1;
        if (imem_rsp_valid_i) begin
          inst_d  = imem_rsp_inst_i;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // ebreak retires here; it never reaches WB so pc/regfile stay frozen.
        if (dec_is_ebreak_i) begin
          exit_d  = a0_zero_i;
          ret_d   = ret_q + 32'd1;
          state_d = S_HALT;
        end else if (dec_is_mem_i) begin
          state_d = S_MREQ;
        end else begin
          state_d = S_WB;
        end
      end
      S_MREQ: begin
        waiting = 1'b1;
        if (dmem_req_ready_i) state_d = S_WAIT_D;
      end
      S_WAIT_D: begin
        waiting = 1'b1;
        if (dmem_rsp_valid_i) state_d = S_WB;
      end
      S_WB: begin
        ret_d   = ret_q + 32'd1;
        state_d = S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase

    // Watchdog only fires if the handshake did not complete this cycle.
    if (waiting && (state_d == state_q) && (wd_q == TIMEOUT)) state_d = S_ERR;

    if (state_d != state_q) wd_d = 8'd0;
    else if (waiting)       wd_d = wd_q + 8'd1;
    else                    wd_d = wd_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wd_q    <= 8'd0;
      inst_q  <= NOP;
      ret_q   <= 32'd0;
      exit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      inst_q  <= inst_d;
      ret_q   <= ret_d;
      exit_q  <= exit_d;
    end
  end

  assign imem_req_valid_o = (state_q == S_FETCH);
  assign dmem_req_valid_o = (state_q == S_MREQ);
  assign pc_we_o          = (state_q == S_WB);
  assign reg_we_o         = (state_q == S_WB);
  assign halted_o         = (state_q == S_HALT);
  assign timeout_err_o    = (state_q == S_ERR);
  assign exit_good_o      = exit_q;
  assign inst_o           = inst_q;
  assign retired_o        = ret_q;

endmodule

// File: tb/tb_ysyx_25040105_core_seq.sv
module tb_ysyx_25040105_core_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_rsp_inst, inst;
  logic        dec_is_mem, dec_is_ebreak, a0_zero;
  logic        dmem_req_valid, dmem_req_ready, dmem_rsp_valid;
  logic        pc_we, reg_we, halted, exit_good, timeout_err;
  logic [31:0] retired;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] exp_ret;
  logic [31:0] prev_inst;
  int          pcwe_log[$];

  always #5 clk = ~clk;

  ysyx_25040105_core_seq dut (
    .clk(clk), .rst(rst),
    .imem_req_valid_o(imem_req_valid), .imem_req_ready_i(imem_req_ready),
    .imem_rsp_valid_i(imem_rsp_valid), .imem_rsp_inst_i(imem_rsp_inst),
    .inst_o(inst),
    .dec_is_mem_i(dec_is_mem), .dec_is_ebreak_i(dec_is_ebreak), .a0_zero_i(a0_zero),
    .dmem_req_valid_o(dmem_req_valid), .dmem_req_ready_i(dmem_req_ready),
    .dmem_rsp_valid_i(dmem_rsp_valid),
    .pc_we_o(pc_we), .reg_we_o(reg_we), .halted_o(halted), .exit_good_o(exit_good),
    .timeout_err_o(timeout_err), .retired_o(retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // {imem_req_valid, dmem_req_valid, pc_we, reg_we, halted, timeout_err}
  task automatic chk_o(input string tag, input logic [5:0] expv);
    chk(tag, {26'd0, imem_req_valid, dmem_req_valid, pc_we, reg_we, halted, timeout_err},
        {26'd0, expv});
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_inst = 32'h0;
    dec_is_mem = 0; dec_is_ebreak = 0; a0_zero = 0;
    dmem_req_ready = 0; dmem_rsp_valid = 0;
  endtask

  // Leaves the bench at the negedge of the IDLE cycle following release
  // advanced into the first FETCH cycle (cycle 2, IDLE being cycle 1).
  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_o("reset_outs", 6'b000000);
    chk("reset_inst", inst, 32'h0000_0013);
    chk("reset_retired", retired, 32'd0);
    chk("reset_exit_good", {31'd0, exit_good}, 32'd0);
    exp_ret = 0; prev_inst = 32'h0000_0013; pcwe_log.delete();
    rst = 1; cyc = 1;
    chk_o("idle", 6'b000000);
    tick();
  endtask

  // Fetch with ri cycles of ready low and di idle cycles before the response.
  // A bogus response is offered on the accept cycle and must not be taken.
  task automatic do_fetch(input int ri, input int di, input logic [31:0] word);
    for (int c = 0; c <= ri; c++) begin
      chk_o("fetch", 6'b100000);
      chk("inst_hold_f", inst, prev_inst);
      imem_req_ready = (c == ri);
      imem_rsp_valid = (c == ri);
      imem_rsp_inst  = ~word;
      tick();
    end
    imem_req_ready = 0;
    for (int c = 0; c <= di; c++) begin
      chk_o("wait_i", 6'b000000);
      chk("inst_hold_w", inst, prev_inst);
      imem_rsp_valid = (c == di);
      imem_rsp_inst  = (c == di) ? word : ~word;
      tick();
    end
    imem_rsp_valid = 0;
    chk("inst_latch", inst, word);
  endtask

  task automatic run_inst(input bit mem, input int ri, input int di, input int rd,
                          input int dd, input logic [31:0] word, output int ncyc);
    int start;
    start = cyc;
    dec_is_mem = mem;
    do_fetch(ri, di, word);
    chk_o("exec", 6'b000000);
    tick();
    if (mem) begin
      for (int c = 0; c <= rd; c++) begin
        chk_o("mreq", 6'b010000);
        dmem_req_ready = (c == rd);
        dmem_rsp_valid = (c == rd);
        tick();
      end
      dmem_req_ready = 0;
      for (int c = 0; c <= dd; c++) begin
        chk_o("wait_d", 6'b000000);
        dmem_rsp_valid = (c == dd);
        tick();
      end
      dmem_rsp_valid = 0;
    end
    chk_o("wb", 6'b001100);
    pcwe_log.push_back(cyc);
    tick();
    exp_ret++;
    chk("retired", retired, exp_ret);
    prev_inst = word;
    dec_is_mem = 0;
    ncyc = cyc - start;
  endtask

  task automatic run_ebreak(input bit a0z);
    int start;
    start = cyc;
    dec_is_ebreak = 1; a0_zero = a0z;
    do_fetch(0, 0, 32'h0010_0073);
    chk_o("exec_ebreak", 6'b000000);
    tick();
    dec_is_ebreak = 0;
    exp_ret++;
    chk("ebreak_cycles", cyc - start, 32'd3);
    imem_req_ready = 1; imem_rsp_valid = 1; dmem_rsp_valid = 1;
    for (int c = 0; c < 4; c++) begin
      chk_o("halt", 6'b000010);
      chk("exit_good", {31'd0, exit_good}, {31'd0, a0z});
      chk("halt_retired", retired, exp_ret);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    int n, ri, di, rd, dd, expc;
    bit mem;
    logic [31:0] w;
    idle_inputs();

    // three zero-wait addi: pc_we on cycles 5, 9, 13
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_inst(0, 0, 0, 0, 0, 32'h0010_0093 + (i << 20), n);
      chk("addi_cycles", n, 32'd4);
    end
    chk("pcwe_c0", pcwe_log[0], 32'd5);
    chk("pcwe_c1", pcwe_log[1], 32'd9);
    chk("pcwe_c2", pcwe_log[2], 32'd13);
    chk("retired3", retired, 32'd3);

    // fetch stalled 4 cycles
    run_inst(0, 4, 0, 0, 0, 32'h1234_5093, n);
    chk("stall_cycles", n, 32'd8);
    // zero-wait store, then load with 3-cycle response delay
    run_inst(1, 0, 0, 0, 0, 32'h00a1_2023, n);
    chk("store_cycles", n, 32'd6);
    run_inst(1, 0, 0, 0, 3, 32'h0001_2083, n);
    chk("load_delay_cycles", n, 32'd9);

    // random mix checked against cycle-count arithmetic
    for (int i = 0; i < 30; i++) begin
      mem = 1'($urandom % 2);
      ri = $urandom_range(0, 3); di = $urandom_range(0, 3);
      rd = $urandom_range(0, 3); dd = $urandom_range(0, 3);
      w  = $urandom;
      expc = (ri + 1) + (di + 1) + 1 + (mem ? (rd + 1) + (dd + 1) : 0) + 1;
      run_inst(mem, ri, di, rd, dd, w, n);
      chk("rand_cycles", n, expc);
    end

    // ebreak good trap, then bad trap
    run_ebreak(1'b1);
    do_reset();
    run_ebreak(1'b0);

    // reset in WAIT_D with a late response
    do_reset();
    run_inst(0, 0, 0, 0, 0, 32'h0050_0513, n);
    dec_is_mem = 1;
    do_fetch(0, 0, 32'h0005_2583);
    tick();                                  // EXEC
    dmem_req_ready = 1; tick();              // MREQ accepted
    dmem_req_ready = 0;
    chk_o("in_wait_d", 6'b000000);
    tick();
    rst = 0; dec_is_mem = 0;
    tick();
    dmem_rsp_valid = 1;
    tick();
    chk_o("rst_mid_outs", 6'b000000);
    chk("rst_mid_retired", retired, 32'd0);
    chk("rst_mid_inst", inst, 32'h0000_0013);
    rst = 1; cyc = 1; exp_ret = 0; prev_inst = 32'h0000_0013;
    chk_o("rst_mid_idle", 6'b000000);
    tick();
    chk_o("rst_mid_fetch", 6'b100000);
    dmem_rsp_valid = 0;
    run_inst(0, 0, 0, 0, 0, 32'h0000_0093, n);
    chk("resume_cycles", n, 32'd4);

    // watchdog: no fetch response
    do_reset();
    imem_req_ready = 1; tick();
    imem_req_ready = 0;
    n = 0;
    while (!timeout_err && n < 300) begin
      chk("wd_no_we", {30'd0, pc_we, reg_we}, 32'd0);
      n++;
      tick();
    end
    chk("wd_wait_cycles", n, 32'd256);
    imem_rsp_valid = 1; imem_req_ready = 1;
    for (int c = 0; c < 3; c++) begin
      chk_o("err", 6'b000001);
      tick();
    end
    chk("err_retired", retired, 32'd0);
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
